add_if: RTL and testbench

ADD_IF -- requirements
Module: add_if

---
 rtl/add_if.sv | 98 +++++++++
 tb/tb_add_if.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/add_if.sv
// -----------------------------------------------------------------------------
// add_if : registered WIDTH-bit unsigned adder with optional subtract.
//
// One-clock latency. Operands sampled on a rising edge with in_valid = 1
// produce a WIDTH+1 bit result on sum immediately after that edge. The MSB
// of sum is the carry-out for an add, or the borrow (a < b) for a subtract.
// When in_valid = 0 the previous result and zero flag are held and out_valid
// drops. All outputs come straight from flops.
//
// Parameters
//   WIDTH   operand width in bits (1..32)
//   SUB_EN  1 = op selects add/subtract, 0 = add only (op ignored)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (sum=0, out_valid=0, zero=1)
//   a, b       in   WIDTH-bit unsigned operands
//   in_valid   in   operands valid this cycle
//   op         in   0 = add, 1 = subtract (a - b)
//   sum        out  WIDTH+1 bit registered result
//   out_valid  out  sum was produced by the most recent edge
//   zero       out  low WIDTH bits of the stored result are all zero
// -----------------------------------------------------------------------------
module add_if #(
    parameter int          WIDTH  = 4,
    parameter int unsigned SUB_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             op,
    output logic [WIDTH:0]   sum,
    output logic             out_valid,
    output logic             zero
);

    // Zero detect over the data bits only; the carry/borrow bit is excluded.
    function automatic logic low_bits_zero(input logic [WIDTH:0] value);
        return (value[WIDTH-1:0] == {WIDTH{1'b0}});
    endfunction

    logic [WIDTH:0] a_ext_s;
    logic [WIDTH:0] b_ext_s;
    logic           sub_sel_s;
    logic [WIDTH:0] result_s;
    logic           result_zero_s;

    logic [WIDTH:0] sum_r;
    logic           out_valid_r;
    logic           zero_r;

    // Datapath: zero-extend operands and form the add or subtract result.
    always_comb begin
        a_ext_s       = {1'b0, a};
        b_ext_s       = {1'b0, b};
        sub_sel_s     = 1'b0;
        result_s      = {(WIDTH+1){1'b0}};
        result_zero_s = 1'b1;

        if (SUB_EN != 32'd0) begin
            sub_sel_s = op;
        end else begin
            sub_sel_s = 1'b0;
        end

        // With both operands below 2^WIDTH, the WIDTH+1 bit two's complement
        // difference has its MSB set exactly when a < b, i.e. the borrow.
        if (sub_sel_s) begin
            result_s = a_ext_s - b_ext_s;
        end else begin
            result_s = a_ext_s + b_ext_s;
        end

        result_zero_s = low_bits_zero(result_s);
    end

    // Result registers: reset wins over a coincident valid; idle cycles hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r       <= {(WIDTH+1){1'b0}};
            out_valid_r <= 1'b0;
            zero_r      <= 1'b1;
        end else if (in_valid) begin
            sum_r       <= result_s;
            out_valid_r <= 1'b1;
            zero_r      <= result_zero_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign sum       = sum_r;
    assign out_valid = out_valid_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_add_if.sv
module tb_add_if;

    logic clk;
    logic rst;

    // 4-bit shared stimulus drives one subtract-capable and one add-only DUT.
    logic [3:0] a4, b4;
    logic       v4, op4;
    logic [4:0] sum4s, sum4a;
    logic       ov4s, ov4a, z4s, z4a;

    logic [7:0] a8, b8;
    logic       v8, op8;
    logic [8:0] sum8;
    logic       ov8, z8;

    int errors = 0;
    int checks = 0;

    // Reference state per DUT
    longint m4s_sum, m4a_sum, m8_sum;
    bit     m4s_v, m4a_v, m8_v;
    bit     m4s_z, m4a_z, m8_z;

    add_if #(.WIDTH(4), .SUB_EN(1)) u4s (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4), .op(op4),
        .sum(sum4s), .out_valid(ov4s), .zero(z4s)
    );

    add_if #(.WIDTH(4), .SUB_EN(0)) u4a (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4), .op(op4),
        .sum(sum4a), .out_valid(ov4a), .zero(z4a)
    );

    add_if #(.WIDTH(8), .SUB_EN(1)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8), .op(op8),
        .sum(sum8), .out_valid(ov8), .zero(z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic result as defined by the operation rules.
    function automatic longint ref_res(input int w, input bit sub_en, input bit op,
                                       input longint a, input longint b);
        longint m;
        m = longint'(1) << w;
        if (sub_en && op) begin
            if (a < b) return m + (a - b + m);  // borrow bit plus wrapped low bits
            else       return a - b;
        end
        return a + b;
    endfunction

    task automatic model_upd(input int w, input bit sub_en, input bit r, input bit v,
                             input bit op, input longint a, input longint b,
                             inout longint s, inout bit val, inout bit z);
        longint m;
        m = longint'(1) << w;
        if (r) begin
            s = 0; val = 1'b0; z = 1'b1;
        end else if (v) begin
            s = ref_res(w, sub_en, op, a, b);
            val = 1'b1;
            z = ((s % m) == 0);
        end else begin
            val = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one edge worth of inputs to all DUTs, advance the model, compare.
    task automatic step(input bit r,
                        input bit va, input bit opa, input int aa, input int ba,
                        input bit vb, input bit opb, input int ab, input int bb);
        logic [3:0] ta4, tb4;
        logic [7:0] ta8, tb8;
        ta4 = aa[3:0]; tb4 = ba[3:0];
        ta8 = ab[7:0]; tb8 = bb[7:0];
        rst = r;
        v4 = va; op4 = opa; a4 = ta4; b4 = tb4;
        v8 = vb; op8 = opb; a8 = ta8; b8 = tb8;
        @(posedge clk);
        #1;
        model_upd(4, 1'b1, r, va, opa, longint'(ta4), longint'(tb4), m4s_sum, m4s_v, m4s_z);
        model_upd(4, 1'b0, r, va, opa, longint'(ta4), longint'(tb4), m4a_sum, m4a_v, m4a_z);
        model_upd(8, 1'b1, r, vb, opb, longint'(ta8), longint'(tb8), m8_sum, m8_v, m8_z);
        chk("u4s.sum",       64'(sum4s), 64'(m4s_sum));
        chk("u4s.out_valid", 64'(ov4s),  64'(m4s_v));
        chk("u4s.zero",      64'(z4s),   64'(m4s_z));
        chk("u4a.sum",       64'(sum4a), 64'(m4a_sum));
        chk("u4a.out_valid", 64'(ov4a),  64'(m4a_v));
        chk("u4a.zero",      64'(z4a),   64'(m4a_z));
        chk("u8.sum",        64'(sum8),  64'(m8_sum));
        chk("u8.out_valid",  64'(ov8),   64'(m8_v));
        chk("u8.zero",       64'(z8),    64'(m8_z));
    endtask

    initial begin
        rst = 1'b1; v4 = 1'b0; op4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        v8 = 1'b0; op8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        m4s_sum = 0; m4a_sum = 0; m8_sum = 0;
        m4s_v = 0; m4a_v = 0; m8_v = 0;
        m4s_z = 1; m4a_z = 1; m8_z = 1;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.sum_const", 64'(sum4s), 64'd0);
        chk("reset.zero_const", 64'(z4s), 64'd1);

        // Basic add sequence
        step(0, 1, 0, 4, 3, 0, 0, 0, 0);
        chk("add.4p3", 64'(sum4s), 64'd7);
        step(0, 1, 0, 5, 3, 0, 0, 0, 0);
        chk("add.5p3", 64'(sum4s), 64'd8);
        step(0, 1, 0, 5, 2, 0, 0, 0, 0);
        chk("add.5p2", 64'(sum4s), 64'd7);

        // Carry boundary
        step(0, 1, 0, 15, 15, 0, 0, 0, 0);
        chk("carry.15p15", 64'(sum4s), 64'd30);
        step(0, 1, 0, 15, 1, 0, 0, 0, 0);
        chk("carry.15p1", 64'(sum4s), 64'd16);
        chk("carry.15p1.zero", 64'(z4s), 64'd1);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("carry.0p0.zero", 64'(z4s), 64'd1);

        // Hold behaviour
        step(0, 1, 0, 4, 3, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 9, 9, 0, 0, 0, 0);
            chk("hold.sum", 64'(sum4s), 64'd7);
            chk("hold.out_valid", 64'(ov4s), 64'd0);
        end

        // Subtract (add-only DUT sees the same op and must still add)
        step(0, 1, 1, 7, 3, 0, 0, 0, 0);
        chk("sub.7m3", 64'(sum4s), 64'd4);
        chk("addonly.7p3", 64'(sum4a), 64'd10);
        step(0, 1, 1, 3, 7, 0, 0, 0, 0);
        chk("sub.3m7", 64'(sum4s), 64'd28);
        step(0, 1, 1, 5, 5, 0, 0, 0, 0);
        chk("sub.5m5", 64'(sum4s), 64'd0);
        chk("sub.5m5.zero", 64'(z4s), 64'd1);

        // Reset collision and recovery
        step(1, 1, 0, 4, 3, 1, 0, 4, 3);
        chk("rstcol.sum", 64'(sum4s), 64'd0);
        chk("rstcol.out_valid", 64'(ov4s), 64'd0);
        step(0, 1, 0, 4, 3, 1, 0, 4, 3);
        chk("rstrec.sum", 64'(sum4s), 64'd7);
        chk("rstrec.out_valid", 64'(ov4s), 64'd1);

        // Width scaling
        step(0, 0, 0, 0, 0, 1, 0, 255, 1);
        chk("w8.255p1", 64'(sum8), 64'd256);
        step(0, 0, 0, 0, 0, 1, 0, 200, 100);
        chk("w8.200p100", 64'(sum8), 64'd300);
        step(0, 0, 0, 0, 0, 1, 1, 100, 200);

        // Random back-to-back traffic with occasional idles and resets
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(99, 0) == 0),
                 ($urandom_range(7, 0) != 0), $urandom_range(1, 0) != 0,
                 int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                 ($urandom_range(7, 0) != 0), $urandom_range(1, 0) != 0,
                 int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
